// File: rtl/note_period_pkg.sv
// Shared constants for the note period timer: note index width,
// rest index and the half-period lookup table.
package note_period_pkg;

  localparam int NOTE_IDX_W = 3;

  typedef logic [NOTE_IDX_W-1:0] note_idx_t;

  localparam note_idx_t REST_IDX = 3'd7;

  // Half-period in count ticks per note.
  // The rest entry is zero, so its load reads as done at once.
  function automatic logic [31:0] half_period(
    input note_idx_t idx
  );
    logic [31:0] v;
    unique case (idx)
      3'd0: v = 32'd20;
      3'd1: v = 32'd18;
      3'd2: v = 32'd16;
      3'd3: v = 32'd15;
      3'd4: v = 32'd13;
      3'd5: v = 32'd12;
      3'd6: v = 32'd11;
      3'd7: v = 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/note_down_counter.sv
// Loadable down-counter with tick enable that holds at zero.
// Ports: clk, rst (async low), load_i, load_val_i, tick_i, count_o, zero_o.
module note_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             is_zero;

  assign is_zero = (cnt_q == '0);

  // Load wins over decrement; zero holds instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && !is_zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = is_zero;

endmodule

// File: rtl/note_period_timer.sv
// Note half-period timer: counter side of the count_load/count_done
// handshake. Ports: clk, rst (async low), note_sel, count_load,
// count_done, count, note_idx, rest. Optional prescaler built when
// NOTE_PERIOD_TIMER_PRESCALE_EN is defined.
module note_period_timer
  import note_period_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       note_sel,
  input  logic             count_load,
  output logic             count_done,
  output logic [WIDTH-1:0] count,
  output logic [2:0]       note_idx,
  output logic             rest
);

  logic [31:0]      hp_full;
  logic [WIDTH-1:0] load_val;
  logic             tick;
  note_idx_t        idx_q;
  note_idx_t        idx_d;

  // Table entries are truncated to the counter width.
  assign hp_full  = half_period(note_sel);
  assign load_val = WIDTH'(hp_full);

  always_comb begin
    idx_d = idx_q;
    if (count_load) begin
      idx_d = note_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= REST_IDX;
    end else begin
      idx_q <= idx_d;
    end
  end

`ifdef NOTE_PERIOD_TIMER_PRESCALE_EN
  localparam int PW =
    (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Tick fires on the wrap from PRESCALE-1 to 0; a load
  // restarts the phase so the first tick is a full period away.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (PRESCALE < 2) begin
      tick = 1'b1;
    end else if (count_load) begin
      pre_d = '0;
    end else if (pre_q == PW'(PRESCALE - 1)) begin
      pre_d = '0;
      tick  = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  note_down_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (count_load),
    .load_val_i (load_val),
    .tick_i     (tick),
    .count_o    (count),
    .zero_o     (count_done)
  );

  assign note_idx = idx_q;
  assign rest     = (idx_q == REST_IDX);

endmodule

// File: doc/note_period_timer.md
NOTE_PERIOD_TIMER -- requirements
Module: note_period_timer

Interface
REQ-001 Parameter WIDTH, default 16: counter and count output width in bits.
REQ-002 Parameter PRESCALE, default 4: cycles per count tick; used only when prescaling is compiled in.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 note_sel  input  3  note index sampled on count_load.
REQ-006 count_load  input  1  load request from the note player controller.
REQ-007 count_done  output  1  high while the counter holds zero.
REQ-008 count  output  WIDTH  current counter value.
REQ-009 note_idx  output  3  note index latched at the last accepted load.
REQ-010 rest  output  1  high when the latched note_idx is the rest index (7).

Function
REQ-011 The block SHALL be the counter-side responder to the controller's count_load/count_done handshake.
REQ-012 On a rising edge with count_load=1, count SHALL be set to NOTE_HALF_PERIOD[note_sel] and note_idx SHALL be set to note_sel.
REQ-013 count_load SHALL take priority over decrement on the same edge.
REQ-014 With count_load=0 and count nonzero, count SHALL decrement by 1 on each tick.
REQ-015 A tick SHALL occur every rising edge when prescaling is compiled out.
REQ-016 At zero, count SHALL hold at zero (no wrap-around to all-ones).
REQ-017 count_done SHALL be a combinational decode of count==0, with no extra cycle of latency.
REQ-018 For a load of value P>0 at edge k, count_done SHALL be low after edges k..k+P-1 and high after edge k+P, with no prescaler.
REQ-019 A load of value 0 (rest) SHALL leave count_done high in the cycle after the load.
REQ-020 A load while counting SHALL restart the countdown from the new value; the remaining count SHALL be discarded.
REQ-021 Table values wider than WIDTH SHALL be truncated to the low WIDTH bits.
REQ-022 rest SHALL equal (note_idx == 3'd7).

Reset
REQ-023 While rst=0, outputs SHALL be count=0, count_done=1, note_idx=7, rest=1, and the prescaler SHALL be 0.
REQ-024 Reset asserted mid-countdown SHALL apply immediately, without waiting for a clock edge.
REQ-025 After rst deasserts, the block SHALL stay idle with count_done=1 until the first count_load.

Configuration
REQ-026 Macro NOTE_PERIOD_TIMER_PRESCALE_EN defined: a prescaler counting 0..PRESCALE-1 SHALL generate one tick when it wraps from PRESCALE-1 to 0.
REQ-027 With the macro defined, count_load SHALL clear the prescaler, so a load of P gives count_done high after exactly P*PRESCALE edges.
REQ-028 With the macro defined, PRESCALE<2 SHALL behave as a tick every cycle.
REQ-029 Macro undefined: there SHALL be no prescaler logic, PRESCALE SHALL be ignored, and behaviour SHALL follow REQ-015.

Structure
REQ-030 Package note_period_pkg SHALL hold NOTE_HALF_PERIOD[0..7] = {20,18,16,15,13,12,11,0}, REST_IDX=7, and the note index width (3).
REQ-031 The down-counter with load, hold-at-zero and tick enable SHALL be a sub-module named note_down_counter.
REQ-032 The top level SHALL contain only the table lookup, note_idx register, optional prescaler and output decode.

Verification
REQ-033 Reset release, then idle 3 cycles -> count=0, count_done=1, note_idx=7, rest=1 on every cycle.
REQ-034 Load note_sel=0, no prescaler -> count=20, then 19..1 on successive cycles; count_done first high 20 edges after the load, then stays high.
REQ-035 Load note_sel=2; at count=9 load note_sel=5 -> count=12 next cycle, note_idx=5, count_done low; done 12 edges later.
REQ-036 Load note_sel=7 -> count=0, count_done=1, rest=1 in the next cycle.
REQ-037 Drop rst at count=7 between clock edges -> outputs at reset values immediately; no decrement after rst is released.
REQ-038 With NOTE_PERIOD_TIMER_PRESCALE_EN and PRESCALE=4, load note_sel=3 -> count steps every 4 cycles; count_done high exactly 60 edges after the load.
